// File: rtl/vga_scan_gen.sv
// vga_scan_gen
// Raster timing generator. It produces the pixel coordinate bus (DrawX,
// DrawY) for the color mapper and sprite logic. It also produces the matching
// sync and data-enable outputs, delayed by PIPE pixel periods to line up with
// a registered pixel pipeline, plus a once-per-frame frame_clk pulse.
//
// Ports:
//   Clk        in   1   system clock
//   Reset_n    in   1   asynchronous active-low reset
//   pix_en     out  1   pixel strobe, one Clk cycle in every CLK_DIV
//   DrawX      out  10  horizontal count, 0..H_TOTAL-1
//   DrawY      out  10  vertical count, 0..V_TOTAL-1
//   active     out  1   visible-area flag, aligned with DrawX/DrawY
//   hs         out  1   horizontal sync, active low, lags PIPE pixels
//   vs         out  1   vertical sync, active low, lags PIPE pixels
//   vde        out  1   video data enable, lags PIPE pixels
//   frame_clk  out  1   one-Clk pulse when the raster enters (0, V_ACTIVE)
module vga_scan_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE     = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       active,
  output logic       hs,
  output logic       vs,
  output logic       vde,
  output logic       frame_clk
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Reject geometries the 10-bit counters cannot represent.
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_scan_gen: CLK_DIV must be 1..16");
  end
  if (PIPE < 0 || PIPE > 4) begin : g_bad_pipe
    $error("vga_scan_gen: PIPE must be 0..4");
  end
  if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_total
    $error("vga_scan_gen: horizontal/vertical total exceeds 1023");
  end
  if (H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1 ||
      H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0) begin : g_bad_geom
    $error("vga_scan_gen: illegal timing geometry");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic             hs_raw;
  logic             vs_raw;
  logic             de_raw;
  logic             frame_start;
  logic [PIPE:0]    hs_pipe;
  logic [PIPE:0]    vs_pipe;
  logic [PIPE:0]    de_pipe;

  // Clock divider. pix_en is registered from the terminal count, so the
  // strobe sits in the cycle after div_cnt reached CLK_DIV-1.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end
      pix_en <= (div_cnt == DIV_LAST);
    end
  end

  // Next raster position; all raw windows are judged on this position so
  // that the registered outputs describe the pixel being entered.
  always_comb begin
    x_next = DrawX;
    y_next = DrawY;
    if (DrawX == H_LAST) begin
      x_next = 10'd0;
      if (DrawY == V_LAST) begin
        y_next = 10'd0;
      end else begin
        y_next = DrawY + 10'd1;
      end
    end else begin
      x_next = DrawX + 10'd1;
      y_next = DrawY;
    end
  end

  // Raw (undelayed) sync / enable windows and the frame-start detector.
  always_comb begin
    hs_raw      = ~((x_next >= HS_START) && (x_next <= HS_END));
    vs_raw      = ~((y_next >= VS_START) && (y_next <= VS_END));
    de_raw      = (x_next < H_VIS) && (y_next < V_VIS);
    frame_start = (x_next == 10'd0) && (y_next == V_VIS);
  end

  // Raster counters and the undelayed active flag, advanced once per pixel.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      DrawX  <= 10'd0;
      DrawY  <= 10'd0;
      active <= 1'b1;
    end else if (pix_en) begin
      DrawX  <= x_next;
      DrawY  <= y_next;
      active <= de_raw;
    end else begin
      DrawX  <= DrawX;
      DrawY  <= DrawY;
      active <= active;
    end
  end

  // Sync/DE delay line. Stage 0 loads on the same edge as the counters, so
  // stage PIPE trails DrawX/DrawY by exactly PIPE pixel periods.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
      de_pipe <= '0;
    end else if (pix_en) begin
      hs_pipe[0] <= hs_raw;
      vs_pipe[0] <= vs_raw;
      de_pipe[0] <= de_raw;
      for (int i = 1; i <= PIPE; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        de_pipe[i] <= de_pipe[i-1];
      end
    end else begin
      hs_pipe <= hs_pipe;
      vs_pipe <= vs_pipe;
      de_pipe <= de_pipe;
    end
  end

  // frame_clk is recomputed every cycle, so it can only last one cycle even
  // when CLK_DIV is 1 (the next edge moves the raster off (0, V_ACTIVE)).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_clk <= 1'b0;
    end else begin
      frame_clk <= pix_en && frame_start;
    end
  end

  assign hs  = hs_pipe[PIPE];
  assign vs  = vs_pipe[PIPE];
  assign vde = de_pipe[PIPE];

endmodule
